// File: rtl/phys_free_list.sv
// Physical register free list: one allocation per cycle to rename, reclaim on ROB free, rewind on flush.
// Latency: alloc_reg_o is a zero-latency read of the speculative head; frees become allocatable the next cycle.
// Backpressure: alloc_ready_o drops when no speculative entry remains; misuse sets sticky error_o.
// Optional double-free checking is built when PHYS_FREE_LIST_CHECK_EN is defined.
module phys_free_list #(
  parameter int NUM_PHYS_REG = 128,
  parameter int NUM_ARCH_REG = 16,
  parameter int FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG,
  localparam int REG_W       = $clog2(NUM_PHYS_REG),
  localparam int CNT_W       = $clog2(FL_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alloc_v_i,
  output logic             alloc_ready_o,
  output logic [REG_W-1:0] alloc_reg_o,
  input  logic             commit_alloc_i,
  input  logic             free_v_i,
  input  logic [REG_W-1:0] free_reg_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] free_count_o,
  output logic             error_o
);

  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  logic [REG_W-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0] spec_head, commit_head, tail;
  logic [CNT_W-1:0] spec_count, commit_count;
  logic             error_q;

  logic [PTR_W-1:0] spec_head_nxt, commit_head_nxt, tail_nxt;
  logic [CNT_W-1:0] spec_count_nxt, commit_count_nxt;
  logic             alloc_fire, commit_fire, free_fire;
  logic             alloc_err, commit_err, overflow_err, dbl_free;

  // Explicit wrap so a non-power-of-two depth works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign alloc_ready_o = (spec_count != '0);
  assign alloc_reg_o   = mem[spec_head];
  assign free_count_o  = spec_count;
  assign error_o       = error_q;

  // An allocation in a flush cycle is discarded along with the rest of the speculative state.
  assign alloc_fire   = alloc_v_i & alloc_ready_o & ~flush_i;
  assign alloc_err    = alloc_v_i & ~alloc_ready_o;
  // Commit only makes sense when something is speculatively allocated beyond the committed head.
  assign commit_fire  = commit_alloc_i & (commit_count != spec_count);
  assign commit_err   = commit_alloc_i & (commit_count == spec_count);
  assign free_fire    = free_v_i & (commit_count != CNT_W'(FL_DEPTH));
  assign overflow_err = free_v_i & (commit_count == CNT_W'(FL_DEPTH));

  // Next-state pointers and counts; flush rewinds to the committed view including this cycle's commit/free.
  always_comb begin
    commit_head_nxt  = commit_fire ? ptr_inc(commit_head) : commit_head;
    tail_nxt         = free_fire ? ptr_inc(tail) : tail;
    commit_count_nxt = commit_count + CNT_W'(free_fire) - CNT_W'(commit_fire);
    spec_head_nxt    = alloc_fire ? ptr_inc(spec_head) : spec_head;
    spec_count_nxt   = spec_count + CNT_W'(free_fire) - CNT_W'(alloc_fire);
    if (flush_i) begin
      spec_head_nxt  = commit_head_nxt;
      spec_count_nxt = commit_count_nxt;
    end
  end

  // State register: buffer contents, pointers, counts and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= REG_W'(NUM_ARCH_REG + i);
      end
      spec_head    <= '0;
      commit_head  <= '0;
      tail         <= '0;
      spec_count   <= CNT_W'(FL_DEPTH);
      commit_count <= CNT_W'(FL_DEPTH);
      error_q      <= 1'b0;
    end else begin
      if (free_fire) begin
        mem[tail] <= free_reg_i;
      end
      spec_head    <= spec_head_nxt;
      commit_head  <= commit_head_nxt;
      tail         <= tail_nxt;
      spec_count   <= spec_count_nxt;
      commit_count <= commit_count_nxt;
      error_q      <= error_q | alloc_err | commit_err | overflow_err | dbl_free;
    end
  end

`ifdef PHYS_FREE_LIST_CHECK_EN
  // in_list tracks registers sitting in the free portion; spec_alloc remembers
  // uncommitted allocations so a flush can put their bits back.
  logic [NUM_PHYS_REG-1:0] in_list, in_list_nxt;
  logic [NUM_PHYS_REG-1:0] spec_alloc, spec_alloc_nxt;

  assign dbl_free = free_fire & in_list[free_reg_i];

  // Bitmap updates: commit retires a speculative bit, alloc moves a reg out, free brings one in.
  always_comb begin
    in_list_nxt    = in_list;
    spec_alloc_nxt = spec_alloc;
    if (commit_fire) begin
      spec_alloc_nxt[mem[commit_head]] = 1'b0;
    end
    if (alloc_fire) begin
      in_list_nxt[alloc_reg_o]    = 1'b0;
      spec_alloc_nxt[alloc_reg_o] = 1'b1;
    end
    if (free_fire) begin
      in_list_nxt[free_reg_i] = 1'b1;
    end
    if (flush_i) begin
      in_list_nxt    = in_list_nxt | spec_alloc_nxt;
      spec_alloc_nxt = '0;
    end
  end

  // Bitmap registers; registers above the architectural range start out free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_PHYS_REG; i++) begin
        in_list[i] <= (i >= NUM_ARCH_REG);
      end
      spec_alloc <= '0;
    end else begin
      in_list    <= in_list_nxt;
      spec_alloc <= spec_alloc_nxt;
    end
  end
`else
  assign dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Randomized and directed bench for phys_free_list with a queue-based reference model.
// Driver pushes expected status/alloc results; a negedge monitor pops and compares.
// Bench is free-running; every sequence is a bounded loop.
module tb_phys_free_list;
  localparam int FL_DEPTH = 112;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       alloc_v_i;
  logic       alloc_ready_o;
  logic [6:0] alloc_reg_o;
  logic       commit_alloc_i;
  logic       free_v_i;
  logic [6:0] free_reg_i;
  logic       flush_i;
  logic [6:0] free_count_o;
  logic       error_o;

  phys_free_list dut (
    .clk_i(clk_i), .reset_i(reset_i), .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o),
    .alloc_reg_o(alloc_reg_o), .commit_alloc_i(commit_alloc_i), .free_v_i(free_v_i),
    .free_reg_i(free_reg_i), .flush_i(flush_i), .free_count_o(free_count_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [6:0] cnt;
    logic       rdy;
    logic       err;
    logic [6:0] hd;
  } st_t;

  st_t        status_q[$];
  logic [6:0] alloc_q[$];

  // Reference model: freeq holds the committed free list in order (front = committed head);
  // the first nspec entries have been handed out speculatively.
  logic [6:0] freeq[$];
  int         nspec;
  bit         merr;

  int  checks = 0;
  int  errors = 0;
  bit  done = 0;
  bit  end_checked = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit in_free_part(input logic [6:0] r);
    for (int i = nspec; i < freeq.size(); i++) if (freeq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit present(input logic [6:0] r);
    for (int i = 0; i < freeq.size(); i++) if (freeq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    freeq.delete();
    for (int i = 0; i < FL_DEPTH; i++) freeq.push_back(7'(16 + i));
    nspec = 0;
    merr  = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; alloc_v_i = 1'b0; commit_alloc_i = 1'b0;
    free_v_i = 1'b0; free_reg_i = '0; flush_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  // One cycle: publish expected current status, drive inputs, advance the model.
  task automatic step(input bit a, input bit c, input bit f, input logic [6:0] r, input bit fl);
    st_t s;
    int  cnt;
    bit  ok_a, ok_c, ok_f;
    cnt   = freeq.size() - nspec;
    s.cnt = 7'(cnt);
    s.rdy = (cnt != 0);
    s.err = merr;
    s.hd  = (cnt != 0) ? freeq[nspec] : 7'd0;
    status_q.push_back(s);
    alloc_v_i = a; commit_alloc_i = c; free_v_i = f; free_reg_i = r; flush_i = fl;
    ok_a = a && (cnt != 0) && !fl;
    ok_c = c && (nspec != 0);
    ok_f = f && (freeq.size() != FL_DEPTH);
    if (a && cnt == 0) merr = 1'b1;
    if (c && nspec == 0) merr = 1'b1;
    if (f && !ok_f) merr = 1'b1;
`ifdef PHYS_FREE_LIST_CHECK_EN
    if (ok_f && in_free_part(r)) merr = 1'b1;
`endif
    if (ok_a) begin
      alloc_q.push_back(freeq[nspec]);
      nspec++;
    end
    if (ok_c) begin
      void'(freeq.pop_front());
      nspec--;
    end
    if (ok_f) freeq.push_back(r);
    if (fl) nspec = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 7'd0, 0);
  endtask

  // Monitor: compare status every cycle and each alloc handshake the DUT presents.
  initial begin
    st_t        s;
    logic [6:0] e;
    forever begin
      @(negedge clk_i);
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        check("free_count", int'(free_count_o), int'(s.cnt));
        check("alloc_ready", int'(alloc_ready_o), int'(s.rdy));
        check("error", int'(error_o), int'(s.err));
        if (s.rdy) check("alloc_reg_head", int'(alloc_reg_o), int'(s.hd));
      end
      if (!reset_i && alloc_v_i && alloc_ready_o && !flush_i) begin
        if (alloc_q.size() == 0) begin
          check("unexpected_alloc", int'(alloc_reg_o), -1);
        end else begin
          e = alloc_q.pop_front();
          check("alloc_reg", int'(alloc_reg_o), int'(e));
        end
      end
      if (done && !end_checked) begin
        end_checked = 1'b1;
        check("alloc_q_drained", alloc_q.size(), 0);
        check("status_q_drained", status_q.size(), 0);
      end
    end
  end

  initial begin
    logic [6:0] r;
    bit a, c, f, fl;
    int tries;

    // Reset state, then drain the whole list in order.
    do_reset();
    idle(1);
    for (int i = 0; i < FL_DEPTH; i++) step(1, 0, 0, 7'd0, 0);
    idle(1);
    // Extra alloc on empty list: ignored, error set.
    step(1, 0, 0, 7'd0, 0);
    idle(1);
    // Commit everything, then free reg 20 into the empty list.
    for (int i = 0; i < FL_DEPTH; i++) step(0, 1, 0, 7'd0, 0);
    step(0, 0, 1, 7'd20, 0);
    idle(1);
    step(1, 0, 0, 7'd0, 0);
    idle(1);

    // Alloc 5, commit 2, flush.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 7'd0, 0);
    step(0, 1, 0, 7'd0, 0);
    step(0, 1, 0, 7'd0, 0);
    step(0, 0, 0, 7'd0, 1);
    idle(2);

    // Wrap: drain with commits, refill with a permuted set, drain again across the wrap.
    do_reset();
    for (int i = 0; i < FL_DEPTH; i++) step(1, nspec > 0, 0, 7'd0, 0);
    step(0, 1, 0, 7'd0, 0);
    for (int i = 0; i < FL_DEPTH; i++) step(0, 0, 1, 7'((i * 37 + 5) % 128), 0);
    for (int i = 0; i < FL_DEPTH; i++) step(1, nspec > 0, 0, 7'd0, 0);
    step(0, 1, 0, 7'd0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 7'((i * 13 + 2) % 128), 0);
    for (int i = 0; i < 40; i++) step(1, nspec > 0, 0, 7'd0, 0);
    idle(1);

    // Simultaneous alloc + free with one entry left.
    do_reset();
    for (int i = 0; i < FL_DEPTH - 1; i++) step(1, nspec > 0, 0, 7'd0, 0);
    step(1, 0, 1, 7'd16, 0);
    idle(1);
    step(1, 0, 0, 7'd0, 0);
    idle(1);

    // Free reg 40 twice (double free is flagged only when the bitmap check is built).
    do_reset();
    for (int i = 0; i < 30; i++) step(1, nspec > 0, 0, 7'd0, 0);
    step(0, 1, 0, 7'd0, 0);
    step(0, 0, 1, 7'd40, 0);
    step(0, 0, 1, 7'd40, 0);
    idle(3);

    // Randomized legal traffic with flushes; a mid-run reset.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      a  = ($urandom_range(0, 9) < 6) && (freeq.size() - nspec > 0);
      c  = ($urandom_range(0, 9) < 4) && (nspec > 0);
      fl = ($urandom_range(0, 19) == 0);
      f  = 1'b0;
      r  = '0;
      if ($urandom_range(0, 9) < 4 && freeq.size() < FL_DEPTH) begin
        tries = 0;
        while (tries < 20 && !f) begin
          r = 7'($urandom_range(0, 127));
          if (!present(r)) f = 1'b1;
          tries++;
        end
      end
      step(a, c, f, r, fl);
    end
    idle(2);

    done = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
